ble_config_loader: RTL

//  Serial configuration controller for the array's basic logic elements (BLEs).
//  - Accepts a bitstream one bit per handshake and assembles it in a shadow register.
//  - Commits the assembled data atomically to the active LUT contents (16-bit select

---
 rtl/fpga_cfg_pkg.sv | 15 +
 rtl/cfg_shift_reg.sv | 20 ++
 rtl/ble_config_loader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared configuration-path definitions: LUT/frame geometry and loader FSM states.
package fpga_cfg_pkg;

  localparam int unsigned LUT_BITS   = 16;
  localparam int unsigned FRAME_BITS = LUT_BITS + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PARITY,
    COMMIT,
    ERROR
  } cfg_state_t;

endpackage

// File: rtl/cfg_shift_reg.sv
// Shadow register for the serial bitstream: shifts left, new bit enters at LSB.
module cfg_shift_reg #(
  parameter int unsigned WIDTH = 34
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/ble_config_loader.sv
// Serial BLE configuration loader with atomic commit to the active LUT/FF-bypass registers.
// Optional trailing even-parity bit and ERROR path enabled by defining CFG_PARITY_EN.
module ble_config_loader
  import fpga_cfg_pkg::*;
#(
  parameter int unsigned NUM_BLE = 9
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_start,
  input  logic                        cfg_bit,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  output logic [NUM_BLE*LUT_BITS-1:0] lut_cfg,
  output logic [NUM_BLE-1:0]          ff_sel,
  output logic                        busy,
  output logic                        cfg_done,
  output logic                        cfg_err
);

  localparam int unsigned TOTAL_BITS = NUM_BLE * FRAME_BITS;
  localparam int unsigned CNT_W      = $clog2(TOTAL_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TOTAL_BITS - 1);

  cfg_state_t             state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [TOTAL_BITS-1:0]  shadow;
  logic                   shift_en;
  logic                   commit;

  cfg_shift_reg #(
    .WIDTH (TOTAL_BITS)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .din      (cfg_bit),
    .q        (shadow)
  );

`ifdef CFG_PARITY_EN
  // Shadow holds all data bits; the parity bit is checked on the fly, never stored.
  logic parity_ok;
  assign parity_ok = ~(^shadow ^ cfg_bit);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shift_en = 1'b0;
    commit   = 1'b0;
    cfg_done = 1'b0;
    cfg_err  = 1'b0;
    busy     = (state != IDLE);
`ifdef CFG_PARITY_EN
    cfg_ready = (state == LOAD) || (state == PARITY);
`else
    cfg_ready = (state == LOAD);
`endif
    case (state)
      IDLE: begin
        if (cfg_start) begin
          state_n = LOAD;
          cnt_n   = '0;
        end
      end
      LOAD: begin
        // A restart wins over a bit offered in the same cycle; that bit is dropped.
        if (cfg_start) begin
          cnt_n = '0;
        end else if (cfg_valid) begin
          shift_en = 1'b1;
          cnt_n    = cnt + 1'b1;
          if (cnt == LAST_BIT) begin
`ifdef CFG_PARITY_EN
            state_n = PARITY;
`else
            state_n = COMMIT;
`endif
          end
        end
      end
`ifdef CFG_PARITY_EN
      PARITY: begin
        if (cfg_start) begin
          state_n = LOAD;
          cnt_n   = '0;
        end else if (cfg_valid) begin
          state_n = parity_ok ? COMMIT : ERROR;
        end
      end
      ERROR: begin
        cfg_err = 1'b1;
        state_n = IDLE;
      end
`endif
      COMMIT: begin
        commit   = 1'b1;
        cfg_done = 1'b1;
        state_n  = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lut_cfg <= '0;
      ff_sel  <= '0;
    end else if (commit) begin
      for (int unsigned i = 0; i < NUM_BLE; i++) begin
        lut_cfg[i*LUT_BITS +: LUT_BITS] <= shadow[i*FRAME_BITS +: LUT_BITS];
        ff_sel[i]                       <= shadow[i*FRAME_BITS + LUT_BITS];
      end
    end
  end

endmodule
